// File: rtl/mips_mc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mc_core : multi-cycle MIPS32 subset core, handshaked I/D ports       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module mips_mc_core #(
  parameter logic [31:0] PC_INIT = 32'h8002_0000,
  parameter logic [31:0] SP_INIT = 32'h8010_0000,
  parameter logic [31:0] RA_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halted
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00, FN_JR  = 6'h08, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, result_q, npc_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q, retire_q, halted_q;
  logic [31:0] imem_addr_q, dmem_addr_q, dmem_wdata_q, retire_pc_q;
  logic [31:0] regs_q [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [31:0] w_sext, w_zext, w_pc4, w_br_target, w_j_target, w_alu, w_npc;
  logic        w_legal, w_is_mem, w_misaligned;

  assign w_op         = ir_q[31:26];
  assign w_rs         = ir_q[25:21];
  assign w_rt         = ir_q[20:16];
  assign w_rd         = ir_q[15:11];
  assign w_shamt      = ir_q[10:6];
  assign w_funct      = ir_q[5:0];
  assign w_sext       = {{16{ir_q[15]}}, ir_q[15:0]};
  assign w_zext       = {16'h0000, ir_q[15:0]};
  assign w_pc4        = pc_q + 32'd4;
  assign w_br_target  = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_target   = {w_pc4[31:28], ir_q[25:0], 2'b00};
  assign w_is_mem     = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_misaligned = (w_alu[1:0] != 2'b00);

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_SLL, FN_JR, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: w_legal = 1'b1;
          default:                                                w_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // JAL routes its link value through the ALU result so WB needs one write path
  always_comb begin
    w_alu = 32'h0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADDU: w_alu = a_q + b_q;
          FN_SUBU: w_alu = a_q - b_q;
          FN_AND:  w_alu = a_q & b_q;
          FN_OR:   w_alu = a_q | b_q;
          FN_SLT:  w_alu = {31'h0, $signed(a_q) < $signed(b_q)};
          FN_SLL:  w_alu = b_q << w_shamt;
          default: w_alu = 32'h0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: w_alu = a_q + w_sext;
      OP_ORI:                 w_alu = a_q | w_zext;
      OP_LUI:                 w_alu = {ir_q[15:0], 16'h0000};
      OP_JAL:                 w_alu = w_pc4;
      default:                w_alu = 32'h0;
    endcase
  end

  always_comb begin
    w_npc = w_pc4;
    case (w_op)
      OP_BEQ:     if (a_q == b_q) w_npc = w_br_target;
      OP_BNE:     if (a_q != b_q) w_npc = w_br_target;
      OP_J, OP_JAL: w_npc = w_j_target;
      OP_RTYPE:   if (w_funct == FN_JR) w_npc = a_q;
      default:    w_npc = w_pc4;
    endcase
  end

  always_comb begin
    w_dest = 5'd0;
    case (w_op)
      OP_RTYPE:                      if (w_funct != FN_JR) w_dest = w_rd;
      OP_ADDIU, OP_ORI, OP_LUI, OP_LW: w_dest = w_rt;
      OP_JAL:                        w_dest = 5'd31;
      default:                       w_dest = 5'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_req_q && imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_mem) state_d = w_misaligned ? S_HALT : S_MEM;
        else          state_d = S_WB;
      end
      S_MEM:    if (dmem_ready) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= PC_INIT;
      ir_q         <= 32'h0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      result_q     <= 32'h0;
      npc_q        <= 32'h0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      retire_q     <= 1'b0;
      retire_pc_q  <= 32'h0;
      halted_q     <= 1'b0;
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : 32'h0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      case (state_q)
        S_FETCH: begin
          // Only the first fetch after reset needs to raise req here; WB raises it otherwise
          if (!imem_req_q) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end else if (imem_ready) begin
            imem_req_q <= 1'b0;
            ir_q       <= imem_rdata;
          end
        end
        S_DECODE: begin
          a_q <= regs_q[w_rs];
          b_q <= regs_q[w_rt];
        end
        S_EXEC: begin
          result_q <= w_alu;
          npc_q    <= w_npc;
          if (w_is_mem && !w_misaligned) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= (w_op == OP_SW);
            dmem_addr_q  <= w_alu;
            dmem_wdata_q <= b_q;
          end else if (!w_is_mem) begin
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            if (!dmem_we_q) result_q <= dmem_rdata;
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
          end
        end
        S_WB: begin
          retire_q    <= 1'b0;
          pc_q        <= npc_q;
          imem_req_q  <= 1'b1;
          imem_addr_q <= npc_q;
          if (w_dest != 5'd0) regs_q[w_dest] <= result_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign retire     = retire_q;
  assign retire_pc  = retire_pc_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire
